// File: rtl/keypad_if.sv
// Keypad matrix interface: column strobes out, row returns in, plus key event outputs.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // Scanner side: drives the matrix columns and reports key events.
  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_down
  );

  // Consumer/matrix side: returns rows and observes key events.
  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks active-low column strobes, debounces the active-low
// row returns and reports one registered key event per physical press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 500000
) (
  input  logic     clk,
  input  logic     clr,
  keypad_if.master kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] SCAN       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
  logic [3:0]       code, code_nxt;
  logic             valid, valid_nxt;
  logic             down, down_nxt;
  logic [3:0]       col_drv;
  logic [3:0]       rs_meta, rs;
  logic [1:0]       low_row;
  logic             row_low;

  assign kp.col       = col_drv;
  assign kp.key_code  = code;
  assign kp.key_valid = valid;
  assign kp.key_down  = down;

  // Tracked row still pressed (rows are active-low).
  assign row_low = ~rs[row_idx];

  // Lowest-numbered low row in the synchronized returns.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) low_row = 2'(i);
    end
  end

  // Next-state and next-output logic for the scan/debounce FSM.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    row_idx_nxt = row_idx;
    div_cnt_nxt = div_cnt;
    db_cnt_nxt  = db_cnt;
    code_nxt    = code;
    valid_nxt   = 1'b0;
    down_nxt    = down;

    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          if (rs != 4'b1111) begin
            row_idx_nxt = low_row;
            db_cnt_nxt  = '0;
            div_cnt_nxt = '0;
            state_nxt   = PRESS_DB;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
            div_cnt_nxt = '0;
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      PRESS_DB: begin
        if (!row_low) begin
          // Bounce: drop the candidate and move on to the next column.
          state_nxt   = SCAN;
          col_idx_nxt = col_idx + 2'd1;
          div_cnt_nxt = '0;
          db_cnt_nxt  = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          valid_nxt  = 1'b1;
          code_nxt   = {row_idx, col_idx};
          down_nxt   = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end

      HELD: begin
        if (!row_low) begin
          db_cnt_nxt = '0;
          state_nxt  = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        if (row_low) begin
          // Release glitch: key is still considered down.
          db_cnt_nxt = '0;
          state_nxt  = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = SCAN;
          down_nxt    = 1'b0;
          col_idx_nxt = col_idx + 2'd1;
          div_cnt_nxt = '0;
          db_cnt_nxt  = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end

      default: begin
        state_nxt   = SCAN;
        col_idx_nxt = 2'd0;
        div_cnt_nxt = '0;
        db_cnt_nxt  = '0;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      div_cnt <= '0;
      db_cnt  <= '0;
      code    <= 4'd0;
      valid   <= 1'b0;
      down    <= 1'b0;
      col_drv <= 4'b1110;
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      state   <= state_nxt;
      col_idx <= col_idx_nxt;
      row_idx <= row_idx_nxt;
      div_cnt <= div_cnt_nxt;
      db_cnt  <= db_cnt_nxt;
      code    <= code_nxt;
      valid   <= valid_nxt;
      down    <= down_nxt;
      col_drv <= ~(4'b0001 << col_idx_nxt);
      rs_meta <= kp.row;
      rs      <= rs_meta;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch matrix model.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic clr;
  logic [3:0] pressed [4];

  int total = 0;
  int passed = 0;
  int valid_cnt = 0;
  int consec = 0;
  bit prev_valid = 1'b0;

  keypad_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk (clk),
    .clr (clr),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Matrix: a row reads low when a pressed key in it sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) kif.row[r] = ~(|(pressed[r] & ~kif.col));
  end

  typedef struct {
    logic [3:0] col;
    logic       valid;
    logic       down;
    logic [3:0] code;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one cycle, sampling outputs on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (kif.key_valid) begin
      valid_cnt++;
      if (prev_valid) consec++;
    end
    prev_valid = kif.key_valid;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = kif.key_valid;
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_col(input string name, input logic [3:0] c, input int budget);
    bit seen = (kif.col == c);
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (kif.col == c);
    end
    check({name, "_col_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_release(input string name, input int budget);
    bit seen = !kif.key_down;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = !kif.key_down;
    end
    check({name, "_released"}, 32'(seen), 32'd1);
  endtask

  initial begin
    vec_t vecs [17];
    int   base;
    bit   held_ok;

    vecs = '{
      '{4'b1110, 1'b0, 1'b0, 4'h0}, '{4'b1110, 1'b0, 1'b0, 4'h0},
      '{4'b1110, 1'b0, 1'b0, 4'h0}, '{4'b1110, 1'b0, 1'b0, 4'h0},
      '{4'b1101, 1'b0, 1'b0, 4'h0}, '{4'b1101, 1'b0, 1'b0, 4'h0},
      '{4'b1101, 1'b0, 1'b0, 4'h0}, '{4'b1101, 1'b0, 1'b0, 4'h0},
      '{4'b1011, 1'b0, 1'b0, 4'h0}, '{4'b1011, 1'b0, 1'b0, 4'h0},
      '{4'b1011, 1'b0, 1'b0, 4'h0}, '{4'b1011, 1'b0, 1'b0, 4'h0},
      '{4'b0111, 1'b0, 1'b0, 4'h0}, '{4'b0111, 1'b0, 1'b0, 4'h0},
      '{4'b0111, 1'b0, 1'b0, 4'h0}, '{4'b0111, 1'b0, 1'b0, 4'h0},
      '{4'b1110, 1'b0, 1'b0, 4'h0}
    };

    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;

    // 1: reset values and idle column walk.
    for (int k = 0; k < 17; k++) begin
      if (k > 0) tick();
      check($sformatf("idle_col_%0d", k), 32'(kif.col), 32'(vecs[k].col));
      check($sformatf("idle_valid_%0d", k), 32'(kif.key_valid), 32'(vecs[k].valid));
      check($sformatf("idle_down_%0d", k), 32'(kif.key_down), 32'(vecs[k].down));
      check($sformatf("idle_code_%0d", k), 32'(kif.key_code), 32'(vecs[k].code));
    end

    // 2: press (2,1), hold, release.
    base = valid_cnt;
    pressed[2][1] = 1'b1;
    wait_valid("p2", 64);
    check("p2_code", 32'(kif.key_code), 32'h9);
    check("p2_down", 32'(kif.key_down), 32'd1);
    check("p2_col", 32'(kif.col), 32'(4'b1101));
    tick();
    check("p2_valid_one_cycle", 32'(kif.key_valid), 32'd0);
    held_ok = 1'b1;
    repeat (20) begin
      tick();
      if (kif.col != 4'b1101 || !kif.key_down) held_ok = 1'b0;
    end
    check("p2_col_frozen", 32'(held_ok), 32'd1);
    pressed[2][1] = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) check("p2_down_before_release", 32'(kif.key_down), 32'd1);
    end
    check("p2_down_released", 32'(kif.key_down), 32'd0);
    check("p2_col_resume", 32'(kif.col), 32'(4'b1011));
    check("p2_valid_count", 32'(valid_cnt - base), 32'd1);

    // 3: press bounce on (0,3) lasting 5 cycles.
    base = valid_cnt;
    wait_col("p3", 4'b0111, 32);
    pressed[0][3] = 1'b1;
    repeat (5) tick();
    pressed[0][3] = 1'b0;
    tick();
    tick();
    check("p3_col_frozen", 32'(kif.col), 32'(4'b0111));
    tick();
    check("p3_col_resume", 32'(kif.col), 32'(4'b1110));
    repeat (10) tick();
    check("p3_no_valid", 32'(valid_cnt - base), 32'd0);
    check("p3_code_kept", 32'(kif.key_code), 32'h9);

    // 4: release glitch while held on (3,2).
    base = valid_cnt;
    pressed[3][2] = 1'b1;
    wait_valid("p4", 64);
    check("p4_code", 32'(kif.key_code), 32'hE);
    repeat (3) tick();
    pressed[3][2] = 1'b0;
    held_ok = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 3) pressed[3][2] = 1'b1;
      if (i == 4) pressed[3][2] = 1'b0;
      if (!kif.key_down) held_ok = 1'b0;
    end
    check("p4_down_through_glitch", 32'(held_ok), 32'd1);
    tick();
    check("p4_down_released", 32'(kif.key_down), 32'd0);
    check("p4_col_resume", 32'(kif.col), 32'(4'b0111));
    check("p4_valid_count", 32'(valid_cnt - base), 32'd1);

    // 5: rows 1 and 3 together on column 0.
    base = valid_cnt;
    wait_col("p5", 4'b1011, 32);
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    wait_valid("p5", 64);
    check("p5_code", 32'(kif.key_code), 32'h4);
    pressed[3][0] = 1'b0;
    repeat (20) tick();
    check("p5_row3_ignored", 32'(kif.key_down), 32'd1);
    check("p5_col_frozen", 32'(kif.col), 32'(4'b1110));
    pressed[1][0] = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) check("p5_down_before_release", 32'(kif.key_down), 32'd1);
    end
    check("p5_down_released", 32'(kif.key_down), 32'd0);
    check("p5_valid_count", 32'(valid_cnt - base), 32'd1);

    // 6a: clr while HELD on (0,2), then re-acceptance.
    pressed[0][2] = 1'b1;
    wait_valid("p6a", 64);
    check("p6a_code", 32'(kif.key_code), 32'h2);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("p6a_clr_col", 32'(kif.col), 32'(4'b1110));
    check("p6a_clr_down", 32'(kif.key_down), 32'd0);
    check("p6a_clr_valid", 32'(kif.key_valid), 32'd0);
    check("p6a_clr_code", 32'(kif.key_code), 32'h0);
    base = valid_cnt;
    wait_valid("p6a_again", 64);
    check("p6a_again_code", 32'(kif.key_code), 32'h2);
    check("p6a_again_count", 32'(valid_cnt - base), 32'd1);
    pressed[0][2] = 1'b0;
    wait_release("p6a", 32);

    // 6b: clr mid press-debounce on (1,3), then re-acceptance.
    wait_col("p6b_start", 4'b1110, 32);
    base = valid_cnt;
    pressed[1][3] = 1'b1;
    wait_col("p6b", 4'b0111, 32);
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("p6b_clr_col", 32'(kif.col), 32'(4'b1110));
    check("p6b_clr_down", 32'(kif.key_down), 32'd0);
    check("p6b_clr_valid", 32'(kif.key_valid), 32'd0);
    check("p6b_clr_code", 32'(kif.key_code), 32'h0);
    check("p6b_no_early_valid", 32'(valid_cnt - base), 32'd0);
    wait_valid("p6b_again", 64);
    check("p6b_again_code", 32'(kif.key_code), 32'h7);
    check("p6b_again_count", 32'(valid_cnt - base), 32'd1);
    pressed[1][3] = 1'b0;
    wait_release("p6b", 32);

    check("valid_never_consecutive", 32'(consec), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver.
- The display driver walks active-low anode enables and pushes segment data out. This block walks active-low column strobes across a 4x4 key matrix and reads the active-low row returns back in.
- It debounces the rows and reports one key event per physical press as a registered code plus a single-cycle valid pulse.
- The stopwatch top level uses it to feed go/stop/clr and digit presets.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (1 ms at 50 MHz). Legal minimum is 4.
- DEBOUNCE_CNT, 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz). Legal minimum is 2.

Ports:
- clk  in  1  system clock; single clock domain.
- clr  in  1  reset; synchronous, active-high.
- row  in  4  matrix row returns; active-low, externally pulled up; asynchronous to clk.
- col  out  4  column strobes; active-low; exactly one bit low at all times.
- key_code  out  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}; held until the next accepted key.
- key_valid  out  1  one-cycle pulse when a debounced press is accepted.
- key_down  out  1  high from acceptance until the debounced release.

Behaviour:
- Reset (clr=1 at a clk edge), values on the next cycle:
  - col=4'b1110, key_code=0, key_valid=0, key_down=0.
  - State=SCAN, column index 0, all counters 0, synchronizer flops 4'b1111.
  - clr applies in every state, including mid-debounce and HELD.
- Synchronization: row passes through a 2-flop synchronizer (rs). All decisions use rs, so a row change reaches the decision logic 2 cycles late.
- Column drive: col = ~(4'b0001 << col_idx), registered.
- SCAN:
  - The divider counts 0..SCAN_DIV-1 while the current column is driven.
  - Sampling happens only on the cycle with divider == SCAN_DIV-1.
  - If rs != 4'b1111 on that cycle: latch row_idx = lowest-numbered low bit of rs, keep col_idx, clear the debounce counter, go to PRESS_DB.
  - Otherwise: col_idx advances (3 wraps to 0) and the divider clears.
- PRESS_DB:
  - Column is frozen.
  - Each cycle rs[row_idx]==0: debounce counter +1.
  - If rs[row_idx]==1 on any cycle: abort. Go to SCAN, advance col_idx, clear the divider. No output changes.
  - When the counter == DEBOUNCE_CNT-1 and rs[row_idx]==0: go to HELD. On the next cycle key_valid=1 (exactly one cycle), key_code={row_idx,col_idx} and key_down=1, all registered together.
- HELD:
  - Column is frozen and key_down=1.
  - Other rows and other keys are ignored.
  - When rs[row_idx]==1: clear the counter and go to RELEASE_DB.
- RELEASE_DB:
  - Each cycle rs[row_idx]==1: counter +1.
  - If rs[row_idx]==0: return to HELD with the counter cleared. No new key_valid.
  - When the counter == DEBOUNCE_CNT-1 with the row high: key_down=0 on the next cycle, go to SCAN, advance col_idx, clear the divider.
- Multiple keys:
  - Same column: the lowest row index wins.
  - Different columns: the first column reached in scan order wins.
  - No rollover. A new key is accepted only after a full release.
- Counters: width is $clog2 of the parameter. No wrap-around is possible because every state clears its counter on exit.
- key_valid never asserts on consecutive cycles. key_code is unchanged except at key_valid.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8; the bench models the matrix as row[r]=0 iff key(r,c) is pressed and col[c]=0):
1. Reset, then no keys:
   - col sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held 4 cycles.
   - key_valid=0, key_down=0, key_code=0 throughout.
2. Press key (row 2, col 1) and hold:
   - Exactly one key_valid pulse with key_code=4'h9, and key_down=1 on the same cycle.
   - col stays 1101 while the key is held.
   - After release, key_down=0 once rs[2] has been high for 8 consecutive cycles; scanning resumes at col 1011.
3. Press bounce (row 0, col 3 low for only 5 cycles, then released):
   - No key_valid; key_code unchanged.
   - Scanning resumes at col 1110.
4. Release bounce while HELD (row high 3 cycles, low 1 cycle, high 10 cycles):
   - key_down stays 1 through the glitch and drops 8 cycles after the final rise reaches rs.
   - No second key_valid.
5. Simultaneous keys (rows 1 and 3 in col 0):
   - key_code=4'h4.
   - Releasing row 3 alone has no effect; releasing row 1 ends HELD.
6. clr asserted in HELD and in PRESS_DB:
   - Next cycle: col=1110, key_down=0, key_valid=0, key_code=0.
   - A still-held key is re-accepted by a fresh scan with one new key_valid.
